cdb_result_queue: RTL and testbench

- Per-functional-unit completion buffer between a functional unit (ALU, MUL, DIV, LS, control) and the CDB arbiter.
- Captures each finished result (rd, pd, rob_idx, data, opaque RVFI sideband) and presents the oldest one as a ready-to-commit request.
- Pops the oldest entry in the cycle the arbiter reports this unit as the granted broadcaster.
- Decouples unit completion from CDB arbitration loss so a losing unit never drops or stalls a result inside its datapath.

---
 rtl/cdb_result_queue.sv | 89 ++++++++
 tb/tb_cdb_result_queue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cdb_result_queue.sv
// Completion buffer between one functional unit and the CDB arbiter: holds finished
// results in FIFO order and offers the oldest as a commit request until granted.
module cdb_result_queue #(
  parameter int DEPTH  = 4,
  parameter int PHYS_W = 6,
  parameter int ROB_W  = 5,
  parameter int RVFI_W = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [PHYS_W-1:0]        in_pd,
  input  logic [ROB_W-1:0]         in_rob_idx,
  input  logic [31:0]              in_data,
  input  logic [RVFI_W-1:0]        in_rvfi,
  output logic                     out_valid,
  output logic [4:0]               out_rd,
  output logic [PHYS_W-1:0]        out_pd,
  output logic [ROB_W-1:0]         out_rob_idx,
  output logic [31:0]              out_data,
  output logic [RVFI_W-1:0]        out_rvfi,
  input  logic                     grant,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [4:0]        rd;
    logic [PHYS_W-1:0] pd;
    logic [ROB_W-1:0]  rob_idx;
    logic [31:0]       data;
    logic [RVFI_W-1:0] rvfi;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head_entry;
  logic [PTR_W-1:0]  head, tail;
  logic              push, pop;

  // Full blocks pushes even when a pop lands in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = grant && out_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{rd: in_rd, pd: in_pd, rob_idx: in_rob_idx,
                             data: in_data, rvfi: in_rvfi};
  end

  always_comb begin
    head_entry = '0;
    if (out_valid) head_entry = mem[head];
  end

  assign out_rd      = head_entry.rd;
  assign out_pd      = head_entry.pd;
  assign out_rob_idx = head_entry.rob_idx;
  assign out_data    = head_entry.data;
  assign out_rvfi    = head_entry.rvfi;

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed bench for cdb_result_queue: reset, pass-through, backpressure, wrap,
// full-with-pop and flush priority, each checked against hand-computed values.
module tb_cdb_result_queue;
  localparam int DEPTH = 4, PHYS_W = 6, ROB_W = 5, RVFI_W = 256;

  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, grant;
  logic [4:0] in_rd, out_rd;
  logic [PHYS_W-1:0] in_pd, out_pd;
  logic [ROB_W-1:0] in_rob_idx, out_rob_idx;
  logic [31:0] in_data, out_data;
  logic [RVFI_W-1:0] in_rvfi, out_rvfi;
  logic [2:0] count;
  int n_checks = 0, n_fail = 0;

  cdb_result_queue #(.DEPTH(DEPTH), .PHYS_W(PHYS_W), .ROB_W(ROB_W), .RVFI_W(RVFI_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_pd(in_pd), .in_rob_idx(in_rob_idx), .in_data(in_data), .in_rvfi(in_rvfi),
    .out_valid(out_valid), .out_rd(out_rd), .out_pd(out_pd), .out_rob_idx(out_rob_idx),
    .out_data(out_data), .out_rvfi(out_rvfi), .grant(grant), .count(count));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_push(input logic [31:0] d);
    in_valid = 1'b1; in_data = d; in_rd = d[4:0];
    in_pd = d[PHYS_W-1:0]; in_rob_idx = d[ROB_W-1:0]; in_rvfi = {8{d}};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; in_valid = 0; grant = 0;
    in_rd = 0; in_pd = 0; in_rob_idx = 0; in_data = 0; in_rvfi = '0;
    step(); step(); rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
  endtask

  task automatic test_pass_through();
    in_valid = 1; in_rd = 5; in_pd = 12; in_rob_idx = 3; in_data = 32'hDEADBEEF;
    in_rvfi = {8{32'hA5A5_0001}};
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass got %0b want 0", out_valid); end
    step(); in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid got %0b want 1", out_valid); end
    n_checks++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL pt_rd got %0d want 5", out_rd); end
    n_checks++; if (out_pd !== 6'd12) begin n_fail++; $display("FAIL pt_pd got %0d want 12", out_pd); end
    n_checks++; if (out_rob_idx !== 5'd3) begin n_fail++; $display("FAIL pt_rob got %0d want 3", out_rob_idx); end
    n_checks++; if (out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pt_data got %0h want deadbeef", out_data); end
    n_checks++; if (out_rvfi !== {8{32'hA5A5_0001}}) begin n_fail++; $display("FAIL pt_rvfi got %0h", out_rvfi); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL pt_count got %0d want 1", count); end
    grant = 1; step(); grant = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_pop_valid got %0b want 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL pt_pop_count got %0d want 0", count); end
    n_checks++; if (out_rd !== 5'd0 || out_data !== 32'h0) begin n_fail++; $display("FAIL pt_zero_fields got rd %0d data %0h want 0", out_rd, out_data); end
    // grant on an empty queue must change nothing
    grant = 1; step(); grant = 0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_grant_count got %0d want 0", count); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive_push(i); step();
      n_checks++; if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count, i); end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
    drive_push(5); step(); in_valid = 0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_overflow_count got %0d want 4", count); end
    grant = 1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (out_data !== 32'(i)) begin n_fail++; $display("FAIL fill_order got %0d want %0d", out_data, i); end
      step();
    end
    grant = 0;
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL fill_drained got valid %0b count %0d want 0 0", out_valid, count); end
  endtask

  task automatic test_wrap();
    drive_push(98); step(); drive_push(99); step();
    for (int i = 0; i < 10; i++) begin
      drive_push(100 + i); grant = 1;
      n_checks++; if (out_data !== 32'(98 + i)) begin n_fail++; $display("FAIL wrap_head got %0d want %0d", out_data, 98 + i); end
      step();
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", count); end
    end
    in_valid = 0;
    for (int i = 108; i <= 109; i++) begin
      n_checks++; if (out_data !== 32'(i)) begin n_fail++; $display("FAIL wrap_tail got %0d want %0d", out_data, i); end
      step();
    end
    grant = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin drive_push(200 + i); step(); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fp_full got %0d want 4", count); end
    drive_push(204); grant = 1; step(); in_valid = 0; grant = 0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fp_count got %0d want 3", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fp_in_ready got %0b want 1", in_ready); end
    grant = 1;
    for (int i = 201; i <= 203; i++) begin
      n_checks++; if (out_data !== 32'(i)) begin n_fail++; $display("FAIL fp_order got %0d want %0d", out_data, i); end
      step();
    end
    grant = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_rejected_push got valid %0b data %0d want empty", out_valid, out_data); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive_push(32'h300 + i); step(); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fl_pre got %0d want 3", count); end
    flush = 1; grant = 1; drive_push(32'h399); step(); flush = 0; grant = 0; in_valid = 0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_clear got count %0d valid %0b want 0 0", count, out_valid); end
    drive_push(32'h55); step(); in_valid = 0;
    n_checks++; if (out_data !== 32'h55 || count !== 3'd1) begin n_fail++; $display("FAIL fl_after got data %0h count %0d want 55 1", out_data, count); end
    grant = 1; step(); grant = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    drive_push(32'h77); step(); drive_push(32'h78); rst = 1; flush = 1; step();
    rst = 0; flush = 0; in_valid = 0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid got count %0d valid %0b want 0 0", count, out_valid); end
    drive_push(32'h9); step(); in_valid = 0;
    n_checks++; if (out_data !== 32'h9) begin n_fail++; $display("FAIL rst_mid_push got %0h want 9", out_data); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill();
    test_wrap();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
